// File: rtl/freqdetector.sv
// Schmitt-trigger zero-crossing frequency estimator: measures the period between
// rising crossings and converts it to a phase increment with a restoring divider.
module freqdetector #(
    parameter int BITSIZE = 24,
    parameter int PHASESIZE = 16,
    parameter int PERIODSIZE = 16,
    parameter logic [BITSIZE-1:0] HYST = 24'h010000
) (
    input  logic                 lrclk,
    input  logic                 reset,
    input  logic [BITSIZE-1:0]   sample,
    output logic [PHASESIZE-1:0] freq,
    output logic                 freq_valid,
    output logic                 locked
);

    localparam int DW = $clog2(PHASESIZE + 1);
    localparam logic [DW-1:0] LAST = DW'(PHASESIZE);
    localparam logic [BITSIZE:0] MID = (BITSIZE + 1)'(1) << (BITSIZE - 1);
    localparam logic [BITSIZE:0] THR_HI = MID + {1'b0, HYST};
    localparam logic [BITSIZE:0] THR_LO = MID - {1'b0, HYST};

    typedef enum logic { CMP_LOW, CMP_HIGH } cmp_t;
    typedef enum logic { SEEK, COUNT } meas_t;
    typedef enum logic { DIV_IDLE, DIV_RUN } div_t;

    cmp_t  cmp_q, cmp_d;
    meas_t meas_q, meas_d;
    div_t  div_q, div_d;

    logic                  rise_q;
    logic [PERIODSIZE-1:0] cnt_q, cnt_d;
    logic [PERIODSIZE-1:0] per_q;
    logic [PERIODSIZE-1:0] rem_q, rem_nx;
    logic [PHASESIZE:0]    quo_q, quo_nx;
    logic [DW-1:0]         dcnt_q;
    logic [PERIODSIZE:0]   trial;
    logic                  ge;
    logic                  capture, timeout, start, finish;
    logic [BITSIZE:0]      sample_x;

    assign sample_x = {1'b0, sample};

    always_comb begin
        cmp_d = cmp_q;
        if (cmp_q == CMP_LOW && sample_x >= THR_HI)
            cmp_d = CMP_HIGH;
        else if (cmp_q == CMP_HIGH && sample_x < THR_LO)
            cmp_d = CMP_LOW;
    end

    // Period measurement: cnt counts cycles since the previous rising event.
    always_comb begin
        meas_d  = meas_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (meas_q)
            SEEK: begin
                if (rise_q) begin
                    meas_d = COUNT;
                    cnt_d  = PERIODSIZE'(1);
                end
            end
            COUNT: begin
                if (rise_q) begin
                    capture = 1'b1;
                    cnt_d   = PERIODSIZE'(1);
                end else if (cnt_q == '1) begin
                    timeout = 1'b1;
                    meas_d  = SEEK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PERIODSIZE'(1);
                end
            end
            default: meas_d = SEEK;
        endcase
    end

    // One quotient bit per cycle; the dividend 2^PHASESIZE is shifted out of quo_q.
    assign trial  = {rem_q, quo_q[PHASESIZE]};
    assign ge     = trial >= {1'b0, per_q};
    assign rem_nx = ge ? PERIODSIZE'(trial - {1'b0, per_q}) : trial[PERIODSIZE-1:0];
    assign quo_nx = {quo_q[PHASESIZE-1:0], ge};

    always_comb begin
        div_d  = div_q;
        start  = 1'b0;
        finish = 1'b0;
        case (div_q)
            DIV_IDLE: begin
                if (capture) begin
                    start = 1'b1;
                    div_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (timeout) begin
                    div_d = DIV_IDLE;
                end else if (dcnt_q == LAST) begin
                    finish = 1'b1;
                    div_d  = DIV_IDLE;
                end
            end
            default: div_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge lrclk) begin
        if (reset) begin
            cmp_q      <= CMP_LOW;
            rise_q     <= 1'b0;
            meas_q     <= SEEK;
            cnt_q      <= '0;
            div_q      <= DIV_IDLE;
            per_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dcnt_q     <= '0;
            freq       <= '0;
            freq_valid <= 1'b0;
            locked     <= 1'b0;
        end else begin
            cmp_q  <= cmp_d;
            rise_q <= (cmp_q == CMP_LOW) && (cmp_d == CMP_HIGH);
            meas_q <= meas_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            if (start) begin
                per_q  <= cnt_q;
                rem_q  <= '0;
                quo_q  <= {1'b1, {PHASESIZE{1'b0}}};
                dcnt_q <= '0;
            end else if (div_q == DIV_RUN) begin
                rem_q  <= rem_nx;
                quo_q  <= quo_nx;
                dcnt_q <= dcnt_q + DW'(1);
            end
            freq_valid <= finish;
            if (timeout) begin
                freq   <= '0;
                locked <= 1'b0;
            end else if (finish) begin
                freq   <= quo_nx[PHASESIZE-1:0];
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freqdetector.sv
// Self-checking bench for freqdetector: table-driven square waves, directed corner
// sequences and random stimulus, all compared against an event-timing reference model.
module tb_freqdetector;

    logic        lrclk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] sample = '0;
    logic [15:0] freq;
    logic        freq_valid;
    logic        locked;

    freqdetector #(
        .BITSIZE(24),
        .PHASESIZE(16),
        .PERIODSIZE(16),
        .HYST(24'h010000)
    ) dut (
        .lrclk(lrclk),
        .reset(reset),
        .sample(sample),
        .freq(freq),
        .freq_valid(freq_valid),
        .locked(locked)
    );

    always #5 lrclk = ~lrclk;

    localparam logic [23:0] THR_HI = 24'h810000;
    localparam logic [23:0] THR_LO = 24'h7F0000;
    localparam longint LATENCY = 18;
    localparam longint TIMEOUT_GAP = 65536;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model: tracks rising-crossing times and schedules updates from them.
    typedef struct { longint when; logic [15:0] val; } upd_t;
    upd_t   pending[$];
    longint n = 0;
    longint k0 = 0;
    longint last_start = -1000;
    bit     have_prev = 0;
    bit     m_cmp = 0;
    logic [15:0] m_freq = '0;
    logic        m_valid = 1'b0;
    logic        m_locked = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_edge(input logic r, input logic [23:0] s);
        bit     rise;
        longint p;
        n++;
        m_valid = 1'b0;
        if (r) begin
            m_cmp = 0; have_prev = 0; last_start = -1000;
            pending.delete();
            m_freq = '0; m_locked = 1'b0;
            return;
        end
        rise = !m_cmp && (s >= THR_HI);
        if (!m_cmp && s >= THR_HI) m_cmp = 1;
        else if (m_cmp && s < THR_LO) m_cmp = 0;
        if (have_prev && (n - k0 == TIMEOUT_GAP)) begin
            m_freq = '0; m_locked = 1'b0; have_prev = 0;
            last_start = -1000;
            pending.delete();
        end
        if (rise) begin
            if (have_prev) begin
                p = n - k0;
                if (n - last_start >= LATENCY) begin
                    pending.push_back('{when: n + LATENCY, val: 16'(65536 / p)});
                    last_start = n;
                end
            end
            have_prev = 1;
            k0 = n;
        end
        if (pending.size() > 0 && pending[0].when == n) begin
            m_freq = pending[0].val; m_valid = 1'b1; m_locked = 1'b1;
            void'(pending.pop_front());
        end
    endtask

    task automatic step(input logic r, input logic [23:0] s);
        reset = r;
        sample = s;
        @(posedge lrclk);
        model_edge(r, s);
        #1;
        check("cycle", 32'({freq, freq_valid, locked}), 32'({m_freq, m_valid, m_locked}));
    endtask

    task automatic run_square(input int unsigned period, input logic [23:0] lo,
                              input logic [23:0] hi, input int unsigned ncycles);
        int unsigned ph = 0;
        for (int unsigned i = 0; i < ncycles; i++) begin
            step(1'b0, (ph < period - period / 2) ? lo : hi);
            ph = (ph + 1 == period) ? 0 : ph + 1;
        end
    endtask

    typedef struct {
        int unsigned period;
        logic [23:0] lo;
        logic [23:0] hi;
        logic [15:0] exp_freq;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] acc;
        int unsigned guard;

        vecs[0] = '{period: 100, lo: 24'h000000, hi: 24'hFFFFFF, exp_freq: 16'd655};
        vecs[1] = '{period: 10,  lo: 24'h000000, hi: 24'hFFFFFF, exp_freq: 16'd6553};
        vecs[2] = '{period: 37,  lo: 24'h7EFFFF, hi: 24'h810000, exp_freq: 16'd1771};
        vecs[3] = '{period: 200, lo: 24'h400000, hi: 24'hC00000, exp_freq: 16'd327};
        vecs[4] = '{period: 18,  lo: 24'h000000, hi: 24'hFFFFFF, exp_freq: 16'd3640};
        vecs[5] = '{period: 17,  lo: 24'h000000, hi: 24'hFFFFFF, exp_freq: 16'd3855};
        vecs[6] = '{period: 2,   lo: 24'h000000, hi: 24'hFFFFFF, exp_freq: 16'd32768};

        step(1'b1, 24'h0);
        check("reset_freq", 32'(freq), 32'h0);
        check("reset_valid", 32'(freq_valid), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);

        for (int i = 0; i < 7; i++) begin
            step(1'b1, 24'hFFFFFF);
            step(1'b0, 24'h0);
            run_square(vecs[i].period, vecs[i].lo, vecs[i].hi, vecs[i].period * 8 + 40);
            check($sformatf("vec%0d_freq", i), 32'(freq), 32'(vecs[i].exp_freq));
            check($sformatf("vec%0d_locked", i), 32'(locked), 32'h1);
        end

        // Sawtooth from a 16-bit accumulator stepping by 1024.
        step(1'b1, 24'h0);
        acc = '0;
        for (int unsigned i = 0; i < 64 * 8; i++) begin
            step(1'b0, {acc, 8'h00});
            acc = acc + 16'd1024;
        end
        check("saw_freq", 32'(freq), 32'd1024);
        check("saw_locked", 32'(locked), 32'h1);

        // Reset five cycles after an event that started a division.
        step(1'b1, 24'h0);
        guard = 0;
        begin
            int unsigned ph = 0;
            while (!(last_start > 0 && n == last_start + 5) && guard < 1000) begin
                step(1'b0, (ph < 50) ? 24'h000000 : 24'hFFFFFF);
                ph = (ph + 1 == 100) ? 0 : ph + 1;
                guard++;
            end
        end
        check("midreset_reached", 32'(guard < 1000), 32'h1);
        step(1'b1, 24'hFFFFFF);
        check("midreset_freq", 32'(freq), 32'h0);
        check("midreset_locked", 32'(locked), 32'h0);
        guard = 0;
        for (int unsigned i = 0; i < 30; i++) begin
            step(1'b0, 24'h0);
            if (freq_valid) guard++;
        end
        check("midreset_no_valid", guard, 32'h0);

        // Random square waves with random levels on each side of the thresholds.
        for (int i = 0; i < 8; i++) begin
            run_square($urandom_range(2, 300), 24'($urandom_range(0, 32'h7EFFFF)),
                       24'($urandom_range(32'h810000, 32'hFFFFFF)), 600);
        end
        for (int i = 0; i < 2000; i++) step(1'b0, 24'($urandom));

        // Hysteresis: lock at period 100, then wiggle just inside the dead band.
        step(1'b1, 24'h0);
        step(1'b0, 24'h0);
        run_square(100, 24'h000000, 24'hFFFFFF, 450);
        check("hyst_locked_start", 32'(locked), 32'h1);
        for (int unsigned i = 0; i < 65600; i++) begin
            step(1'b0, i[0] ? 24'h7F0001 : 24'h80FFFF);
            if (i == 60000) begin
                check("hyst_hold_freq", 32'(freq), 32'd655);
                check("hyst_hold_locked", 32'(locked), 32'h1);
            end
        end
        check("timeout_freq", 32'(freq), 32'h0);
        check("timeout_locked", 32'(locked), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freqdetector.md
FREQDETECTOR -- requirements
Module: freqdetector

Interface
REQ-001 SHALL have parameter BITSIZE, default 24, meaning the input sample width.
REQ-002 SHALL have parameter PHASESIZE, default 16, meaning the output frequency-word width, matching the phase-increment word of the sine/triangle generators.
REQ-003 SHALL have parameter PERIODSIZE, default 16, meaning the period counter width.
REQ-004 SHALL have parameter HYST, default 24'h010000, meaning the Schmitt hysteresis half-width in sample LSBs.
REQ-005 SHALL have port lrclk, input, 1 bit: the only clock; one sample per rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port sample, input, BITSIZE bits: unsigned offset-binary audio, midpoint MID = 2^(BITSIZE-1).
REQ-008 SHALL have port freq, output, PHASESIZE bits: latest estimated phase increment.
REQ-009 SHALL have port freq_valid, output, 1 bit: one-cycle pulse when freq updates.
REQ-010 SHALL have port locked, output, 1 bit: high while freq holds a current estimate.

Function
REQ-011 SHALL run a comparator state cmp (LOW/HIGH): LOW->HIGH when sample >= MID+HYST; HIGH->LOW when sample < MID-HYST; otherwise hold. Comparisons are unsigned, with no overflow at the parameter defaults.
REQ-012 SHALL assert a registered rising event for exactly the cycle on which cmp goes LOW->HIGH.
REQ-013 SHALL run a measurement FSM with states SEEK and COUNT: SEEK->COUNT on an event, setting cnt=1; in COUNT, cnt increments by 1 each non-event cycle.
REQ-014 SHALL, on an event while in COUNT, capture period P = cnt (lrclk cycles between the two events), reload cnt=1, and remain in COUNT.
REQ-015 SHALL treat cnt reaching 2^PERIODSIZE-1 without an event as a timeout: state->SEEK, freq<=0, locked<=0, no freq_valid, and any in-flight division aborted.
REQ-016 SHALL compute freq = floor(2^PHASESIZE / P) with a sequential restoring divider using a PHASESIZE+1-bit dividend and one quotient bit per cycle.
REQ-017 SHALL keep the divider in states DIV_IDLE and DIV_RUN; a captured P starts DIV_RUN only from DIV_IDLE.
REQ-018 SHALL discard a captured P if the divider is in DIV_RUN; the period count still restarts.
REQ-019 SHALL give fixed latency: an event on cycle t that starts a division produces freq update, freq_valid=1 and locked=1 on cycle t+PHASESIZE+2.
REQ-020 SHALL hold freq unchanged between updates; freq_valid SHALL be high only on the update cycle.
REQ-021 SHALL guarantee P >= 2 through the hysteresis, so the quotient is <= 2^(PHASESIZE-1) and never overflows PHASESIZE bits.
REQ-022 SHALL give the timeout priority when a timeout and a divider completion fall on the same cycle.

Reset
REQ-023 SHALL, when reset=1 at a lrclk edge, set freq=0, freq_valid=0, locked=0, cmp=LOW, cnt=0, FSM=SEEK, divider=DIV_IDLE.
REQ-024 SHALL not emit freq_valid for a division interrupted by reset; the first valid output after reset requires two new events.
REQ-025 SHALL give reset priority over all other events on the same cycle.

Verification
REQ-026 SHALL cover reset: any prior state, reset high 1 cycle -> next cycle freq=0, freq_valid=0, locked=0.
REQ-027 SHALL cover a square wave of period 100 samples alternating 0x000000/0xFFFFFF -> freq=655 (0x028F), freq_valid pulses once per period starting 18 cycles after the second rising edge, locked=1.
REQ-028 SHALL cover a sawtooth from a 16-bit phase accumulator with increment 1024, upper bits padded to 24 -> P=64, freq=1024 every period.
REQ-029 SHALL cover hysteresis: input MID±(HYST-1) alternating every sample after lock -> no new events; timeout after 65535 samples -> freq=0, locked=0.
REQ-030 SHALL cover a short period: a square wave of period 10 (< PHASESIZE+2) -> alternate captures discarded, freq=6553 on every update, no corrupted values.
REQ-031 SHALL cover reset mid-operation: reset asserted 5 cycles after a capturing event -> no freq_valid; outputs at reset values.
